// File: rtl/axis_round_robin_arbiter.sv
// Round-robin grant sequencer for an AXI-Stream N:1 mux; the grant is held per packet or per beat.
// One-hot select is registered one cycle after a request; handover to the next requester happens on the completing edge.
module axis_round_robin_arbiter #(
  parameter int CHANNEL_NUM = 8,
  parameter int PACKET_MODE = 1,
  localparam int IDX_W = $clog2(CHANNEL_NUM)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [CHANNEL_NUM-1:0] en_i,
  input  logic [CHANNEL_NUM-1:0] s_axis_tvalid,
  input  logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  input  logic                   m_axis_tlast,
  output logic [CHANNEL_NUM-1:0] sel_o,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic                   busy_o,
  output logic                   pkt_done_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_nxt;
  logic [CHANNEL_NUM-1:0] req, sel_nxt;
  logic [IDX_W-1:0]       ptr, ptr_nxt, idx_nxt, grant_inc, base, pick_idx;
  logic                   pick_vld, done, done_nxt;

  // First requester at or after b, wrapping past the top channel back to 0.
  function automatic logic [IDX_W:0] rr_pick(input logic [CHANNEL_NUM-1:0] r,
                                             input logic [IDX_W-1:0] b);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      j = int'(b) + i;
      if (j >= CHANNEL_NUM) j = j - CHANNEL_NUM;
      if (!found && r[IDX_W'(j)]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    return {found, idx};
  endfunction

  assign req       = s_axis_tvalid & en_i;
  assign done      = m_axis_tvalid & m_axis_tready & (m_axis_tlast | (PACKET_MODE == 0));
  assign grant_inc = (grant_idx_o == IDX_W'(CHANNEL_NUM - 1)) ? '0 : grant_idx_o + IDX_W'(1);
  // While busy the search starts just past the current owner, so it ends up lowest priority.
  assign base      = (state == BUSY) ? grant_inc : ptr;
  assign {pick_vld, pick_idx} = rr_pick(req, base);
  assign busy_o    = (state == BUSY);

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_o;
    idx_nxt   = grant_idx_o;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = BUSY;
          sel_nxt   = CHANNEL_NUM'(1) << pick_idx;
          idx_nxt   = pick_idx;
        end
      end
      BUSY: begin
        if (done) begin
          ptr_nxt  = grant_inc;
          done_nxt = 1'b1;
          if (pick_vld) begin
            sel_nxt = CHANNEL_NUM'(1) << pick_idx;
            idx_nxt = pick_idx;
          end else begin
            state_nxt = IDLE;
            sel_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      sel_o       <= '0;
      grant_idx_o <= '0;
      ptr         <= '0;
      pkt_done_o  <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel_o       <= sel_nxt;
      grant_idx_o <= idx_nxt;
      ptr         <= ptr_nxt;
      pkt_done_o  <= done_nxt;
    end
  end

endmodule
